ps2_frame_receiver: RTL
=======================

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on ps2Clk and ps2Data, legal 2..4.
REQ-002 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a ps2Clk level change, legal 2..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles between falling edges inside a frame.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ps2Clk, input, 1: raw PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ps2Data, input, 1: raw PS/2 data line, asynchronous to clk.
REQ-008 SHALL have port scanCodeForCheck, output, 8: last received data byte, for the downstream parity checker.
REQ-009 SHALL have port parityCheckBit, output, 1: last received parity bit, paired with scanCodeForCheck.
REQ-010 SHALL have port frameValid, output, 1: one-cycle pulse when a well-formed frame completes.
REQ-011 SHALL have port frameError, output, 1: one-cycle pulse on a framing error or timeout.

Function
REQ-012 SHALL pass ps2Clk and ps2Data through SYNC_STAGES flops each before use.
REQ-013 SHALL update the filtered clock only after FILTER_LEN consecutive equal synchronized samples; shorter glitches are ignored.
REQ-014 SHALL detect a falling edge as filtered clock going 1->0, flagged for exactly one clk cycle.
REQ-015 SHALL sample synchronized ps2Data only in falling-edge cycles.
REQ-016 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: falling edge with data 0 (start bit) -> DATA with bit counter 0; data 1 -> stay IDLE, no pulse.
REQ-018 DATA: each falling edge shifts data in LSB first and increments the counter; after the 8th bit -> PARITY.
REQ-019 PARITY: falling edge captures the parity bit -> STOP; no parity evaluation occurs in this block.
REQ-020 STOP: falling edge with data 1 -> load scanCodeForCheck and parityCheckBit, pulse frameValid in the next clk cycle, -> IDLE.
REQ-021 STOP: falling edge with data 0 -> pulse frameError, leave the outputs unchanged, -> IDLE.
REQ-022 scanCodeForCheck and parityCheckBit SHALL change only on a valid stop, and stay stable until the next valid frame.
REQ-023 frameValid and frameError SHALL never be high in the same cycle and SHALL be low in all other cycles.
REQ-024 Latency: frameValid SHALL rise exactly 1 clk after the cycle flagging the stop-bit falling edge.

Reset
REQ-025 On rst high, immediately and asynchronously: state IDLE, counters 0, shift register 0x00, scanCodeForCheck 0x00, parityCheckBit 0, frameValid 0, frameError 0, synchronizers and filtered clock 1 (bus idle).
REQ-026 Reset mid-frame SHALL discard the partial frame with no pulse; reception restarts at the next start bit after rst falls.

Configuration
REQ-027 Macro PS2_RX_TIMEOUT_EN SHALL control the inter-edge watchdog.
REQ-028 With PS2_RX_TIMEOUT_EN defined: in DATA, PARITY or STOP the watchdog counts clk cycles since the last falling edge and clears on each edge; on reaching TIMEOUT_CYCLES -> frameError pulse, -> IDLE, outputs unchanged.
REQ-029 Without PS2_RX_TIMEOUT_EN: no watchdog logic; an incomplete frame waits in its state indefinitely.

Verification
REQ-030 Frame start 0, data 0x1C LSB first, parity 0, stop 1 -> one frameValid pulse; scanCodeForCheck=0x1C, parityCheckBit=0; frameError stays 0.
REQ-031 Frame data 0xA5, parity 1, stop 0 -> one frameError pulse, no frameValid; outputs keep the prior 0x1C/0.
REQ-032 ps2Clk low glitch of FILTER_LEN-1 cycles while IDLE with data 0 -> no state change; a following real frame with 0x5A decodes correctly.
REQ-033 rst pulse after 4 data bits, then a full frame with 0xF0 -> only one frameValid, scanCodeForCheck=0xF0.
REQ-034 With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=1000: stop ps2Clk after 5 data bits -> frameError exactly 1000 cycles after the last edge, then IDLE; without the macro -> no pulse for 5000 cycles.
REQ-035 ps2Data held high through an IDLE falling edge -> no pulse, state stays IDLE.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: synchronises and de-glitches the PS/2 clock, then
// deserialises 11-bit frames (start, 8 data LSB first, parity, stop).
// The parity bit is only captured here; a downstream block checks it.
// Optional inter-edge watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_frame_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] scanCodeForCheck,
    output logic       parityCheckBit,
    output logic       frameValid,
    output logic       frameError
);

    localparam int FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

    // Elaboration-time guard on the legal parameter ranges
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gBadSync
        $error("SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : gBadFilter
        $error("FILTER_LEN must be 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rxStateT;

    logic [SYNC_STAGES-1:0] clkSync;
    logic [SYNC_STAGES-1:0] dataSync;
    logic                   syncClk;
    logic                   syncData;
    logic                   filtClk;
    logic [FiltW-1:0]       filtCnt;
    logic                   fallEdge;
    rxStateT                state;
    logic [2:0]             bitCnt;
    logic [7:0]             shiftReg;
    logic                   parityReg;

    assign syncClk  = clkSync[SYNC_STAGES-1];
    assign syncData = dataSync[SYNC_STAGES-1];

    // Synchronizer chains; reset to the idle-high bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkSync  <= '1;
            dataSync <= '1;
        end else begin
            clkSync  <= {clkSync[SYNC_STAGES-2:0], ps2Clk};
            dataSync <= {dataSync[SYNC_STAGES-2:0], ps2Data};
        end
    end

    // Glitch filter: accept a level change after FILTER_LEN differing samples,
    // and flag the 1->0 transition for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtClk  <= 1'b1;
            filtCnt  <= '0;
            fallEdge <= 1'b0;
        end else begin
            fallEdge <= 1'b0;
            if (syncClk == filtClk) begin
                filtCnt <= '0;
            end else if (filtCnt == FiltLast) begin
                filtCnt  <= '0;
                filtClk  <= syncClk;
                fallEdge <= ~syncClk;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    // Holds k in the k-th cycle after the last edge-flag cycle
    logic [TmoW-1:0] wdCnt;
`endif

    // Frame FSM with registered outputs and result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            bitCnt           <= '0;
            shiftReg         <= 8'h00;
            parityReg        <= 1'b0;
            scanCodeForCheck <= 8'h00;
            parityCheckBit   <= 1'b0;
            frameValid       <= 1'b0;
            frameError       <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            wdCnt            <= '0;
`endif
        end else begin
            frameValid <= 1'b0;
            frameError <= 1'b0;
            if (fallEdge) begin
`ifdef PS2_RX_TIMEOUT_EN
                wdCnt <= TmoW'(1);
`endif
                unique case (state)
                    StIdle: begin
                        if (!syncData) begin
                            state  <= StData;
                            bitCnt <= '0;
                        end
                    end
                    StData: begin
                        shiftReg <= {syncData, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            state <= StParity;
                        end
                    end
                    StParity: begin
                        parityReg <= syncData;
                        state     <= StStop;
                    end
                    StStop: begin
                        if (syncData) begin
                            scanCodeForCheck <= shiftReg;
                            parityCheckBit   <= parityReg;
                            frameValid       <= 1'b1;
                        end else begin
                            frameError <= 1'b1;
                        end
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (state != StIdle) begin
                if (wdCnt == TmoLast) begin
                    frameError <= 1'b1;
                    state      <= StIdle;
                end else begin
                    wdCnt <= wdCnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule
